hdmi_burst_sched: RTL
=====================

Name: hdmi_burst_sched

Overview:
- Sequences DDR read bursts for the HDMI output path.
- Each go_fill_fifo_I pulse, with its line address, is split into BURSTS_PER_FILL fixed-length read bursts on the memory master port.
- Returned words stream into the pixel FIFO.
- Sits between the fill-FIFO address FSM and the DDR read master; also handles vsync abort and FIFO overflow.

Parameters:
- BURST_WORDS, 16: words per burst; power of 2, ≥2.
- BURSTS_PER_FILL, 4: bursts per fill request (half FIFO = 64 words).
- BYTES_PER_WORD, 4: address increment per word.
- WDOG_CYCLES, 255: idle-data timeout; used only with the optional feature.

Ports:
- clk, in, 1: system clock, rising edge.
- reset, in, 1: asynchronous, active-high reset.
- go_fill_fifo_I, in, 1: one-cycle fill request.
- fill_addr_I, in, 32: byte address of the first word, sampled with go.
- abort_I, in, 1: vsync abort pulse.
- mst_req_O, out, 1: burst request, held until ack.
- mst_addr_O, out, 32: burst start byte address.
- mst_ack_I, in, 1: master accepted the request.
- rd_valid_I, in, 1: read data word valid.
- rd_data_I, in, 32: read data word.
- fifo_full_I, in, 1: pixel FIFO full.
- fifo_wr_en_O, out, 1: FIFO write strobe.
- fifo_wr_data_O, out, 32: FIFO write data.
- busy_O, out, 1: high in any state except IDLE.
- done_O, out, 1: one-cycle pulse when a fill completes normally.
- overrun_O, out, 1: one-cycle pulse when go arrives while busy.
- overflow_O, out, 1: sticky; a word was dropped because the FIFO was full.
- timeout_O, out, 1: one-cycle watchdog pulse; tied 0 when the feature is off.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, overflow cleared. Reset mid-burst discards everything; in-flight rd_valid after release is ignored while in IDLE.
- States: IDLE, REQ, DATA, DRAIN.
- IDLE
  - go=1 and abort=0: latch cur_addr=fill_addr_I, burst_cnt=0, go to REQ.
  - mst_req_O rises the cycle after go (latency 1).
  - go and abort in the same cycle: abort wins; stay IDLE, no pulse.
- REQ
  - mst_req_O=1, mst_addr_O=cur_addr, both held stable until ack.
  - mst_ack_I=1: word_cnt=0, go to DATA, req drops the next cycle.
  - abort_I=1 without ack: return to IDLE, no burst issued.
  - abort and ack in the same cycle: treated as accepted; go to DRAIN.
- DATA
  - On rd_valid_I: fifo_wr_en_O=1 and fifo_wr_data_O=rd_data_I, registered (1-cycle latency); word_cnt++.
  - rd_valid with fifo_full_I=1: word is not written, still counted; overflow_O set until reset.
  - Last word of a burst (word_cnt==BURST_WORDS-1 with valid):
    - if burst_cnt==BURSTS_PER_FILL-1: done_O pulses the next cycle, go to IDLE;
    - else burst_cnt++, cur_addr += BURST_WORDS*BYTES_PER_WORD (mod 2^32, wraps silently), go to REQ.
  - abort_I=1: go to DRAIN; the current word, if valid in that cycle, is still counted but not written.
- DRAIN
  - Counts the remaining words of the accepted burst with writes suppressed (the master cannot cancel a burst).
  - Last word received: go to IDLE; no done_O.
- go_fill_fifo_I in any non-IDLE state: ignored; overrun_O pulses the next cycle.
- Back-to-back: go in the cycle after done_O returns to IDLE is accepted normally.
- rd_valid_I outside DATA/DRAIN: ignored.

Optional Feature:
- Macro: HDMI_BURST_WDOG_EN.
- Defined:
  - An 8-bit+ counter runs in DATA/DRAIN, cleared on each rd_valid_I.
  - Reaching WDOG_CYCLES: pulse timeout_O, go to IDLE, no done_O.
- Undefined: no counter; the FSM waits indefinitely; timeout_O constant 0.

Decomposition:
- Package hdmi_out_pkg holds:
  - state encoding (IDLE=0, REQ=1, DATA=2, DRAIN=3);
  - the address-increment constant BURST_BYTES = BURST_WORDS*BYTES_PER_WORD;
  - default parameter values shared with the fill-FIFO FSM.
- Sub-module hdmi_burst_wdog: watchdog counter, instantiated only under HDMI_BURST_WDOG_EN.
- Everything else stays flat.

Test Plan:
- Normal fill:
  - go with addr 0x80000000, ack after 2 cycles, 16 valid words per burst.
  - Required: bursts at 0x80000000, 0x80000040, 0x80000080, 0x800000C0; 64 FIFO writes in order; single done_O.
- Abort:
  - abort in REQ of burst 2: IDLE next cycle, exactly 16 writes total, no done_O.
  - abort mid-DATA at word 5: words 6–15 drained unwritten, then IDLE.
- Overrun and overflow:
  - go during DATA: overrun_O single pulse; addresses unchanged.
  - fifo_full_I during word 3: 63 writes, overflow_O stays 1 until reset.
- Wrap and simultaneous events:
  - fill_addr 0xFFFFFFC0: second burst address 0x00000000.
  - go+abort in the same IDLE cycle: no request.
- Reset and watchdog:
  - reset asserted mid-DATA: all outputs 0 asynchronously; stray rd_valid afterwards causes no writes.
  - With HDMI_BURST_WDOG_EN, stall data 255 cycles: timeout_O pulse, then IDLE.

Source files
------------

// File: rtl/hdmi_out_pkg.sv
// Shared constants for the HDMI output path: burst FSM state encoding and
// default sizing common to the fill-FIFO FSM and the burst scheduler.
package hdmi_out_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam int unsigned DEF_BURST_WORDS     = 16;
    localparam int unsigned DEF_BURSTS_PER_FILL = 4;
    localparam int unsigned DEF_BYTES_PER_WORD  = 4;
    localparam int unsigned DEF_WDOG_CYCLES     = 255;

    // Byte distance between consecutive burst start addresses.
    function automatic logic [31:0] burst_bytes(input int unsigned words, input int unsigned bpw);
        return 32'(words * bpw);
    endfunction

    localparam logic [31:0] BURST_BYTES = burst_bytes(DEF_BURST_WORDS, DEF_BYTES_PER_WORD);

endpackage

// File: rtl/hdmi_burst_wdog.sv
// Idle-data watchdog for the burst scheduler (built only with HDMI_BURST_WDOG_EN).
// hit_c fires on the WDOG_CYCLES-th consecutive running cycle without a data word.
module hdmi_burst_wdog
    import hdmi_out_pkg::*;
#(
    parameter int unsigned WDOG_CYCLES = DEF_WDOG_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic kick,
    output logic hit_c
);

    localparam int unsigned CNT_W = ($clog2(WDOG_CYCLES) > 8) ? $clog2(WDOG_CYCLES) : 8;

    logic [CNT_W-1:0] cnt;

    assign hit_c = run && !kick && (cnt == CNT_W'(WDOG_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!run || kick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hdmi_burst_sched.sv
// Splits each fill request into fixed-length DDR read bursts and streams the
// returned words into the pixel FIFO. Optional watchdog: HDMI_BURST_WDOG_EN.
module hdmi_burst_sched
    import hdmi_out_pkg::*;
#(
`ifdef HDMI_BURST_WDOG_EN
    parameter int unsigned WDOG_CYCLES     = DEF_WDOG_CYCLES,
`endif
    parameter int unsigned BURST_WORDS     = DEF_BURST_WORDS,
    parameter int unsigned BURSTS_PER_FILL = DEF_BURSTS_PER_FILL,
    parameter int unsigned BYTES_PER_WORD  = DEF_BYTES_PER_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go_fill_fifo_I,
    input  logic [31:0] fill_addr_I,
    input  logic        abort_I,
    output logic        mst_req_O,
    output logic [31:0] mst_addr_O,
    input  logic        mst_ack_I,
    input  logic        rd_valid_I,
    input  logic [31:0] rd_data_I,
    input  logic        fifo_full_I,
    output logic        fifo_wr_en_O,
    output logic [31:0] fifo_wr_data_O,
    output logic        busy_O,
    output logic        done_O,
    output logic        overrun_O,
    output logic        overflow_O,
    output logic        timeout_O
);

    localparam int unsigned WC_W = $clog2(BURST_WORDS);
    localparam int unsigned BC_W = (BURSTS_PER_FILL > 1) ? $clog2(BURSTS_PER_FILL) : 1;
    localparam logic [WC_W-1:0] WORD_LAST  = WC_W'(BURST_WORDS - 1);
    localparam logic [BC_W-1:0] BURST_LAST = BC_W'(BURSTS_PER_FILL - 1);
    localparam logic [31:0]     ADDR_INC   = burst_bytes(BURST_WORDS, BYTES_PER_WORD);

    logic [1:0]      state, state_nx;
    logic [31:0]     cur_addr, cur_addr_nx;
    logic [BC_W-1:0] burst_cnt, burst_cnt_nx;
    logic [WC_W-1:0] word_cnt, word_cnt_nx;
    logic            req_nx, wr_en_nx, busy_nx, done_nx, overrun_nx, overflow_nx;
    logic [31:0]     addr_nx, wr_data_nx;
    logic            wdog_hit_c;

`ifdef HDMI_BURST_WDOG_EN
    hdmi_burst_wdog #(
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_wdog (
        .clk   (clk),
        .reset (reset),
        .run   ((state == ST_DATA) || (state == ST_DRAIN)),
        .kick  (rd_valid_I),
        .hit_c (wdog_hit_c)
    );
`else
    assign wdog_hit_c = 1'b0;
`endif

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nx     = state;
        cur_addr_nx  = cur_addr;
        burst_cnt_nx = burst_cnt;
        word_cnt_nx  = word_cnt;
        wr_en_nx     = 1'b0;
        wr_data_nx   = fifo_wr_data_O;
        done_nx      = 1'b0;
        overrun_nx   = go_fill_fifo_I && (state != ST_IDLE);
        overflow_nx  = overflow_O;

        case (state)
            ST_IDLE: begin
                if (go_fill_fifo_I && !abort_I) begin
                    cur_addr_nx  = fill_addr_I;
                    burst_cnt_nx = '0;
                    state_nx     = ST_REQ;
                end
            end
            ST_REQ: begin
                // An ack wins over a coincident abort: the burst is already committed.
                if (mst_ack_I) begin
                    word_cnt_nx = '0;
                    state_nx    = abort_I ? ST_DRAIN : ST_DATA;
                end else if (abort_I) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (wdog_hit_c) begin
                    state_nx = ST_IDLE;
                end else begin
                    if (rd_valid_I) begin
                        word_cnt_nx = word_cnt + WC_W'(1);
                        if (!abort_I) begin
                            if (fifo_full_I) begin
                                overflow_nx = 1'b1;
                            end else begin
                                wr_en_nx   = 1'b1;
                                wr_data_nx = rd_data_I;
                            end
                        end
                    end
                    if (rd_valid_I && (word_cnt == WORD_LAST)) begin
                        if (abort_I) begin
                            state_nx = ST_IDLE;
                        end else if (burst_cnt == BURST_LAST) begin
                            done_nx  = 1'b1;
                            state_nx = ST_IDLE;
                        end else begin
                            burst_cnt_nx = burst_cnt + BC_W'(1);
                            cur_addr_nx  = cur_addr + ADDR_INC;
                            state_nx     = ST_REQ;
                        end
                    end else if (abort_I) begin
                        state_nx = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (wdog_hit_c) begin
                    state_nx = ST_IDLE;
                end else if (rd_valid_I) begin
                    word_cnt_nx = word_cnt + WC_W'(1);
                    if (word_cnt == WORD_LAST) begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        req_nx  = (state_nx == ST_REQ);
        addr_nx = req_nx ? cur_addr_nx : mst_addr_O;
        busy_nx = (state_nx != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            cur_addr       <= '0;
            burst_cnt      <= '0;
            word_cnt       <= '0;
            mst_req_O      <= 1'b0;
            mst_addr_O     <= '0;
            fifo_wr_en_O   <= 1'b0;
            fifo_wr_data_O <= '0;
            busy_O         <= 1'b0;
            done_O         <= 1'b0;
            overrun_O      <= 1'b0;
            overflow_O     <= 1'b0;
            timeout_O      <= 1'b0;
        end else begin
            state          <= state_nx;
            cur_addr       <= cur_addr_nx;
            burst_cnt      <= burst_cnt_nx;
            word_cnt       <= word_cnt_nx;
            mst_req_O      <= req_nx;
            mst_addr_O     <= addr_nx;
            fifo_wr_en_O   <= wr_en_nx;
            fifo_wr_data_O <= wr_data_nx;
            busy_O         <= busy_nx;
            done_O         <= done_nx;
            overrun_O      <= overrun_nx;
            overflow_O     <= overflow_nx;
            timeout_O      <= wdog_hit_c;
        end
    end

endmodule
